// File: rtl/rps_match_controller.sv
// rps_match_controller: sequences a multi-round stone-paper-scissors match around the round evaluator.
module rps_match_controller #(
  parameter int WIN_TARGET     = 2,
  parameter int MAX_ROUNDS     = 9,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_match,
  input  logic             abort,
  input  logic [1:0]       p1_move,
  input  logic             p1_lock,
  input  logic [1:0]       p2_move,
  input  logic             p2_lock,
  output logic             eval_req,
  output logic [1:0]       eval_p1,
  output logic [1:0]       eval_p2,
  input  logic             eval_done,
  input  logic [1:0]       eval_winner,
  output logic [CNT_W-1:0] score_p1,
  output logic [CNT_W-1:0] score_p2,
  output logic [CNT_W-1:0] round_cnt,
  output logic [1:0]       last_result,
  output logic             match_over,
  output logic [1:0]       match_winner,
  output logic             err,
  output logic [2:0]       state_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    COLLECT = 3'b001,
    EVAL    = 3'b010,
    SHOW    = 3'b011,
    DONE    = 3'b100
  } state_t;

  state_t           state_q, state_d;
  logic             start_low_q, start_low_d;
  logic             p1_lk_q, p1_lk_d, p2_lk_q, p2_lk_d;
  logic [1:0]       p1_mv_q, p1_mv_d, p2_mv_q, p2_mv_d;
  logic [1:0]       last_q, last_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] s1_q, s1_d, s2_q, s2_d, rnd_q, rnd_d;
  logic             err_q, err_d;
  logic             start_rise, p1_take, p2_take, p1_bad, p2_bad, one_locked;

  // start_low_q remembers that start_match was low, so a level held through reset is not an edge
  assign start_rise = start_match & start_low_q;
  assign p1_take    = (state_q == COLLECT) && p1_lock && !p1_lk_q && (p1_move != 2'b11);
  assign p2_take    = (state_q == COLLECT) && p2_lock && !p2_lk_q && (p2_move != 2'b11);
  assign p1_bad     = (state_q == COLLECT) && p1_lock && !p1_lk_q && (p1_move == 2'b11);
  assign p2_bad     = (state_q == COLLECT) && p2_lock && !p2_lk_q && (p2_move == 2'b11);
  assign one_locked = p1_lk_q ^ p2_lk_q;

  always_comb begin
    state_d     = state_q;
    start_low_d = ~start_match;
    p1_lk_d     = p1_lk_q;
    p2_lk_d     = p2_lk_q;
    p1_mv_d     = p1_mv_q;
    p2_mv_d     = p2_mv_q;
    last_d      = last_q;
    timer_d     = '0;
    s1_d        = s1_q;
    s2_d        = s2_q;
    rnd_d       = rnd_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          s1_d    = '0;
          s2_d    = '0;
          rnd_d   = '0;
          last_d  = 2'b00;
          p1_lk_d = 1'b0;
          p2_lk_d = 1'b0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (p1_take) begin
          p1_lk_d = 1'b1;
          p1_mv_d = p1_move;
        end
        if (p2_take) begin
          p2_lk_d = 1'b1;
          p2_mv_d = p2_move;
        end
        err_d   = p1_bad | p2_bad;
        timer_d = one_locked ? timer_q + 1'b1 : '0;
        // a lock arriving in the timeout cycle takes precedence over the forfeit
        if (p1_lk_d && p2_lk_d) begin
          state_d = EVAL;
          timer_d = '0;
        end else if (one_locked && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          s1_d    = p1_lk_q ? s1_q + 1'b1 : s1_q;
          s2_d    = p2_lk_q ? s2_q + 1'b1 : s2_q;
          rnd_d   = rnd_q + 1'b1;
          last_d  = p1_lk_q ? 2'b01 : 2'b10;
          p1_lk_d = 1'b0;
          p2_lk_d = 1'b0;
          timer_d = '0;
          state_d = SHOW;
        end
      end
      EVAL: begin
        if (eval_done) begin
          p1_lk_d = 1'b0;
          p2_lk_d = 1'b0;
          if (eval_winner == 2'b11) begin
            err_d   = 1'b1;
            state_d = COLLECT;
          end else begin
            s1_d    = (eval_winner == 2'b01) ? s1_q + 1'b1 : s1_q;
            s2_d    = (eval_winner == 2'b10) ? s2_q + 1'b1 : s2_q;
            rnd_d   = rnd_q + 1'b1;
            last_d  = eval_winner;
            state_d = SHOW;
          end
        end
      end
      SHOW: begin
        state_d = (s1_q == CNT_W'(WIN_TARGET) || s2_q == CNT_W'(WIN_TARGET) ||
                   rnd_q == CNT_W'(MAX_ROUNDS)) ? DONE : COLLECT;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      s1_d    = '0;
      s2_d    = '0;
      rnd_d   = '0;
      last_d  = 2'b00;
      p1_lk_d = 1'b0;
      p2_lk_d = 1'b0;
      timer_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      start_low_q <= 1'b0;
      p1_lk_q     <= 1'b0;
      p2_lk_q     <= 1'b0;
      p1_mv_q     <= 2'b00;
      p2_mv_q     <= 2'b00;
      last_q      <= 2'b00;
      timer_q     <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      rnd_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_low_q <= start_low_d;
      p1_lk_q     <= p1_lk_d;
      p2_lk_q     <= p2_lk_d;
      p1_mv_q     <= p1_mv_d;
      p2_mv_q     <= p2_mv_d;
      last_q      <= last_d;
      timer_q     <= timer_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      rnd_q       <= rnd_d;
      err_q       <= err_d;
    end
  end

  assign eval_req     = (state_q == EVAL);
  assign eval_p1      = p1_mv_q;
  assign eval_p2      = p2_mv_q;
  assign score_p1     = s1_q;
  assign score_p2     = s2_q;
  assign round_cnt    = rnd_q;
  assign last_result  = last_q;
  assign match_over   = (state_q == DONE);
  assign match_winner = (state_q != DONE) ? 2'b00 : (s1_q > s2_q) ? 2'b01 : (s2_q > s1_q) ? 2'b10 : 2'b00;
  assign err          = err_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_rps_match_controller.sv
// tb_rps_match_controller: scoreboard bench; round results are queued at stimulus time and checked in SHOW.
module tb_rps_match_controller;
  logic       clk = 1'b0, reset = 1'b1, start_match = 1'b0, abort = 1'b0;
  logic       p1_lock = 1'b0, p2_lock = 1'b0, eval_done = 1'b0;
  logic [1:0] p1_move = 2'b00, p2_move = 2'b00, eval_winner = 2'b00;
  logic       eval_req, match_over, err;
  logic [1:0] eval_p1, eval_p2, last_result, match_winner;
  logic [3:0] score_p1, score_p2, round_cnt;
  logic [2:0] state_o;

  typedef struct packed {
    logic [1:0] last;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] rnd;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0, n_pass = 0;
  logic [3:0] m_s1 = 0, m_s2 = 0, m_rnd = 0;

  rps_match_controller dut (
    .clk(clk), .reset(reset), .start_match(start_match), .abort(abort),
    .p1_move(p1_move), .p1_lock(p1_lock), .p2_move(p2_move), .p2_lock(p2_lock),
    .eval_req(eval_req), .eval_p1(eval_p1), .eval_p2(eval_p2),
    .eval_done(eval_done), .eval_winner(eval_winner),
    .score_p1(score_p1), .score_p2(score_p2), .round_cnt(round_cnt),
    .last_result(last_result), .match_over(match_over), .match_winner(match_winner),
    .err(err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] w);
    exp_t e;
    if (w == 2'b01) m_s1 = m_s1 + 1;
    if (w == 2'b10) m_s2 = m_s2 + 1;
    m_rnd = m_rnd + 1;
    e = {w, m_s1, m_s2, m_rnd};
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && state_o == 3'b011) begin
      if (sb.size() == 0) check("sb_unexpected_show", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("show_last", last_result, e.last);
        check("show_s1", score_p1, e.s1);
        check("show_s2", score_p2, e.s2);
        check("show_rnd", round_cnt, e.rnd);
      end
    end
  end

  task automatic start_game();
    start_match = 1'b1;
    tick();
    start_match = 1'b0;
    @(negedge clk);
    check("start_state", state_o, 3'b001);
    check("start_s1", score_p1, 0);
    check("start_s2", score_p2, 0);
    check("start_rnd", round_cnt, 0);
    check("start_over", match_over, 0);
    m_s1 = 0;
    m_s2 = 0;
    m_rnd = 0;
  endtask

  task automatic eval_phase(input logic [1:0] m1, input logic [1:0] m2, input logic [1:0] w);
    @(negedge clk);
    check("eval_state", state_o, 3'b010);
    check("eval_req", eval_req, 1);
    check("eval_p1", eval_p1, m1);
    check("eval_p2", eval_p2, m2);
    tick();
    tick();
    check("eval_p1_hold", eval_p1, m1);
    if (w != 2'b11) push(w);
    eval_done = 1'b1;
    eval_winner = w;
    tick();
    eval_done = 1'b0;
    eval_winner = 2'b00;
    @(negedge clk);
    if (w == 2'b11) begin
      check("bad_eval_err", err, 1);
      check("bad_eval_state", state_o, 3'b001);
      check("bad_eval_rnd", round_cnt, m_rnd);
    end else check("eval_req_drop", eval_req, 0);
    tick();
  endtask

  task automatic play_round(input logic [1:0] m1, input logic [1:0] m2, input logic [1:0] w);
    p1_move = m1;
    p2_move = m2;
    p1_lock = 1'b1;
    p2_lock = 1'b1;
    tick();
    p1_lock = 1'b0;
    p2_lock = 1'b0;
    eval_phase(m1, m2, w);
  endtask

  initial begin
    int  n;
    bit  seen;
    // reset state
    repeat (2) @(negedge clk);
    check("rst_state", state_o, 0);
    check("rst_req", eval_req, 0);
    check("rst_s1", score_p1, 0);
    check("rst_rnd", round_cnt, 0);
    check("rst_over", match_over, 0);
    check("rst_err", err, 0);
    check("rst_last", last_result, 0);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    // win by target
    start_game();
    play_round(2'b00, 2'b10, 2'b01);
    play_round(2'b00, 2'b10, 2'b01);
    @(negedge clk);
    check("win_over", match_over, 1);
    check("win_winner", match_winner, 2'b01);
    check("win_state", state_o, 3'b100);
    check("win_rnd", round_cnt, 2);
    // ties up to the round limit
    start_game();
    for (int r = 0; r < 9; r++) begin
      logic [1:0] mv;
      mv = 2'(r % 3);
      play_round(mv, mv, 2'b00);
      if (r == 3) begin
        @(negedge clk);
        check("tie_continue", state_o, 3'b001);
      end
    end
    @(negedge clk);
    check("tie_over", match_over, 1);
    check("tie_winner", match_winner, 2'b00);
    check("tie_rnd", round_cnt, 9);
    // invalid lock, then invalid evaluator result, then replay
    start_game();
    p1_move = 2'b11;
    p2_move = 2'b01;
    p1_lock = 1'b1;
    p2_lock = 1'b1;
    tick();
    p1_lock = 1'b0;
    p2_lock = 1'b0;
    @(negedge clk);
    check("bad_lock_err", err, 1);
    check("bad_lock_nolatch", state_o, 3'b001);
    p1_move = 2'b00;
    p1_lock = 1'b1;
    tick();
    p1_lock = 1'b0;
    eval_phase(2'b00, 2'b01, 2'b11);
    play_round(2'b00, 2'b01, 2'b10);
    // timeout forfeit: P2 locks, P1 never does
    push(2'b10);
    p2_move = 2'b01;
    p2_lock = 1'b1;
    tick();
    p2_lock = 1'b0;
    n = 0;
    seen = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (eval_req) seen = 1;
      if (state_o == 3'b011) begin
        n = i;
        break;
      end
    end
    check("to_cycles", n, 256);
    check("to_no_req", seen, 0);
    tick();
    @(negedge clk);
    check("to_over", match_over, 1);
    check("to_winner", match_winner, 2'b10);
    // lock arriving in the timeout cycle proceeds to EVAL
    start_game();
    p2_move = 2'b10;
    p2_lock = 1'b1;
    tick();
    p2_lock = 1'b0;
    repeat (254) tick();
    p1_move = 2'b00;
    p1_lock = 1'b1;
    tick();
    p1_lock = 1'b0;
    eval_phase(2'b00, 2'b10, 2'b01);
    // abort together with eval_done
    p1_move = 2'b00;
    p2_move = 2'b10;
    p1_lock = 1'b1;
    p2_lock = 1'b1;
    tick();
    p1_lock = 1'b0;
    p2_lock = 1'b0;
    @(negedge clk);
    check("abort_pre_req", eval_req, 1);
    tick();
    tick();
    eval_done = 1'b1;
    eval_winner = 2'b01;
    abort = 1'b1;
    tick();
    eval_done = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("abort_state", state_o, 0);
    check("abort_s1", score_p1, 0);
    check("abort_rnd", round_cnt, 0);
    check("abort_last", last_result, 0);
    check("abort_req", eval_req, 0);
    // reset in the middle of EVAL with start_match held high
    start_game();
    play_round(2'b01, 2'b00, 2'b01);
    p1_move = 2'b10;
    p2_move = 2'b01;
    p1_lock = 1'b1;
    p2_lock = 1'b1;
    tick();
    p1_lock = 1'b0;
    p2_lock = 1'b0;
    start_match = 1'b1;
    @(negedge clk);
    check("mid_req", eval_req, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_req", eval_req, 0);
    check("mid_rst_state", state_o, 0);
    check("mid_rst_s1", score_p1, 0);
    check("mid_rst_rnd", round_cnt, 0);
    check("mid_rst_p1", eval_p1, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("held_start_idle", state_o, 0);
    start_match = 1'b0;
    tick();
    start_game();
    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rps_match_controller.md
Name: rps_match_controller

Overview:
- Sequences a multi-round stone-paper-scissors match around the single-round evaluator datapath.
- Collects a locked-in move from each player and hands the pair to the evaluator over a req/done handshake.
- Keeps the score and round count, forfeits a stalled player after a timeout, and declares the match winner.
- Sits between the board-level input decode and the round evaluator; its outputs drive the uo_out display mux.

Parameters:
- WIN_TARGET, 2: round wins needed to take the match (2 = best of 3).
- MAX_ROUNDS, 9: counted rounds after which the match ends regardless of score.
- TIMEOUT_CYCLES, 255: cycles the second player has to lock after the first player locks.
- CNT_W, 4: width of the score and round counters; must satisfy 2^CNT_W > MAX_ROUNDS.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start_match  in  1  level input; a rising edge, detected internally, starts a match
- abort  in  1  synchronous clear to IDLE
- p1_move  in  2  player 1 move: 00 stone, 01 paper, 10 scissors, 11 invalid
- p1_lock  in  1  player 1 commits p1_move
- p2_move  in  2  player 2 move, same encoding
- p2_lock  in  1  player 2 commits p2_move
- eval_req  out  1  request to the round evaluator
- eval_p1  out  2  latched player 1 move, held while eval_req is high
- eval_p2  out  2  latched player 2 move, held while eval_req is high
- eval_done  in  1  evaluator result is valid this cycle
- eval_winner  in  2  00 tie, 01 player 1, 10 player 2, 11 invalid
- score_p1  out  CNT_W  round wins for player 1
- score_p2  out  CNT_W  round wins for player 2
- round_cnt  out  CNT_W  completed counted rounds
- last_result  out  2  most recent round outcome, same encoding as eval_winner
- match_over  out  1  high while in DONE
- match_winner  out  2  00 draw, 01 player 1, 10 player 2; valid while match_over is high
- err  out  1  one-cycle pulse on an invalid lock or an invalid evaluator result
- state_o  out  3  current state for debug

Behaviour:
- State encoding: IDLE=000, COLLECT=001, EVAL=010, SHOW=011, DONE=100. Unused codes go to IDLE.
- Reset: every output and register is 0 and the state is IDLE. The start_match edge detector register also resets to 0, so start_match held high through reset does not start a match.
- abort has priority over every other event in every state. Next cycle: IDLE, scores, round_cnt, last_result and locks cleared, eval_req=0.
- IDLE or DONE + rising edge of start_match:
  - clear scores, round_cnt, last_result, match_winner and both locks;
  - go to COLLECT.
- COLLECT, lock handling:
  - p1_lock with p1_move != 11 and player 1 not yet locked latches the move. Later locks are ignored until the next round.
  - A lock carrying move 11 is not latched and pulses err. Same rules for player 2.
  - Both players may lock in the same cycle.
- COLLECT, timer:
  - Starts at 0 in the cycle after the first single lock and increments every cycle while exactly one player is locked.
  - When it reaches TIMEOUT_CYCLES-1 and the other player is still unlocked, the locked player wins the round: their score +1, round_cnt +1, last_result updated, go to SHOW. The evaluator is not used.
  - A lock arriving in that same cycle wins over the timeout and the round proceeds to EVAL.
- COLLECT to EVAL: in the cycle both locks are set (registered), the next state is EVAL.
- EVAL:
  - eval_req=1, and eval_p1/eval_p2 stay stable until eval_done is sampled.
  - On eval_done: 01 or 10 increments the matching score; 00 increments no score. In all three cases round_cnt +1, last_result=eval_winner, locks clear, go to SHOW.
  - On 11: err pulse, round_cnt unchanged, locks clear, go back to COLLECT (the round is replayed).
  - eval_req drops in the cycle after eval_done is sampled. eval_done outside EVAL is ignored.
- SHOW: lasts exactly one cycle, then goes to:
  - DONE if either score equals WIN_TARGET;
  - otherwise DONE if round_cnt equals MAX_ROUNDS;
  - otherwise COLLECT.
- DONE:
  - match_winner = the player whose score is higher, or 00 if the scores are equal.
  - Scores and round_cnt hold until the next start_match rising edge.
- Counter widths: counters are CNT_W bits and never wrap, because MAX_ROUNDS bounds them.

Test Plan:
- Win by target: start; per round lock P1=00, P2=10, with eval_winner=01 returned 2 cycles after eval_req -> score_p1 reaches 2 after 2 rounds, round_cnt=2, match_over=1, match_winner=01.
- Ties to the round limit: 9 rounds each returning eval_winner=00 -> round_cnt=9, both scores 0, DONE with match_winner=00.
- Timeout forfeit: P2 locks 01 and P1 never locks -> after TIMEOUT_CYCLES, score_p2=1, last_result=10, eval_req never asserted.
- Invalid input: p1_lock with p1_move=11 -> err pulse and no latch. Then an evaluator returning 11 -> err pulse, round_cnt unchanged, state back to COLLECT.
- Simultaneous events: both locks in one cycle -> EVAL next cycle. A lock in the timeout cycle -> EVAL, not a forfeit. abort together with eval_done -> IDLE with scores 0.
- Reset mid-EVAL: assert reset while eval_req=1 -> all outputs 0 and IDLE immediately. start_match held high through reset does not restart the match until it has gone low and risen again.
